// File: rtl/shares_refresh_buf_pkg.sv
// -----------------------------------------------------------------------------
// shares_refresh_buf_pkg
//   Shared constants and share-slicing helpers for the masked-share refresh
//   buffer (shares_refresh_buf) and its storage sub-module (shares_buf2).
//
//   Contents:
//     STALL_CNT_W  width of the randomness-starvation counter (16)
//     BUF_DEPTH    number of entries held by the buffer (2)
//     OCC_W        width of the occupancy counter (holds 0..BUF_DEPTH)
//     occ_t        occupancy counter type
//     share_lsb()  bit offset of share idx inside a packed share vector
//     share_msb()  top bit of share idx inside a packed share vector
// -----------------------------------------------------------------------------
package shares_refresh_buf_pkg;

    localparam int STALL_CNT_W = 16;
    localparam int BUF_DEPTH   = 2;
    localparam int OCC_W       = 2;

    typedef logic [OCC_W-1:0] occ_t;

    // Share idx occupies bits [idx*w +: w] of a packed share vector.
    function automatic int share_lsb(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic int share_msb(input int idx, input int w);
        return (idx * w) + w - 1;
    endfunction

endpackage

// File: rtl/shares_buf2.sv
// -----------------------------------------------------------------------------
// shares_buf2
//   Two-entry FIFO storage for refreshed share vectors. Holds the entries,
//   1-bit read/write pointers and an occupancy counter (0..2). An entry is
//   zeroed when it is popped so no stale share value stays in storage.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset (clears all state)
//     push       in   write wr_data at the tail (ignored when full)
//     pop        in   drop the head entry (ignored when empty)
//     wr_data    in   DATA_W  entry to write
//     rd_data    out  DATA_W  head entry (reads 0 when empty)
//     occupancy  out  number of entries held
// -----------------------------------------------------------------------------
module shares_buf2
    import shares_refresh_buf_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output occ_t              occupancy
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full  = (occupancy == OCC_W'(BUF_DEPTH));
    assign empty = (occupancy == '0);

    // Guard locally too, so the storage can never over/underflow even if
    // the caller asserts push/pop at the wrong time.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // With occupancy 1 the two pointers differ, so a same-cycle push and pop
    // touch different entries; with occupancy 0 or 2 only one of them can
    // happen. The zeroing write and the data write therefore never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= '0;
        end else begin
            if (do_pop) begin
                mem[rd_ptr] <= '0;
                rd_ptr      <= ~rd_ptr;
            end
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Head entry straight from a register; vacated entries are zero, so an
    // empty buffer presents all-zero shares.
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/shares_refresh_buf.sv
// -----------------------------------------------------------------------------
// shares_refresh_buf
//   Re-masks a d-share Boolean-masked value with fresh randomness and buffers
//   the refreshed shares in a 2-entry FIFO. Share i (i < d-1) is XORed with
//   r_i; the last share is XORed with the XOR of all r_i, so the unmasked
//   value (XOR of all shares) is unchanged. Only registered shares reach the
//   outputs.
//
//   Handshake: a transfer on a valid/ready pair happens in a cycle where both
//   are high. Input push needs in_valid & in_ready & rnd_valid together;
//   rnd_ready is high exactly in the push cycle. in_ready depends only on the
//   occupancy (never on out_ready). Output pop is out_valid & out_ready.
//
//   Parameters: d (share count, >=2), W (bits per share).
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   asynchronous active-high reset
//     in_shares   in   d*W      share i at [i*W +: W]
//     in_valid    in   upstream data valid
//     in_ready    out  buffer has a free entry
//     rnd         in   (d-1)*W  r_i at [i*W +: W]
//     rnd_valid   in   randomness available
//     rnd_ready   out  randomness consumed this cycle
//     out_shares  out  d*W      head entry, same layout as in_shares
//     out_valid   out  head entry valid
//     out_ready   in   downstream accepts
//     stall_cnt   out  16       cycles starved of randomness
//
//   Build option: define SHARES_REFRESH_STALL_CNT_EN to count cycles where an
//   input is offered and accepted-able but rnd_valid is low (saturating at
//   0xFFFF, cleared only by rst). Without it stall_cnt is constant 0.
// -----------------------------------------------------------------------------
module shares_refresh_buf
    import shares_refresh_buf_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [d*W-1:0]         in_shares,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [(d-1)*W-1:0]     rnd,
    input  logic                   rnd_valid,
    output logic                   rnd_ready,
    output logic [d*W-1:0]         out_shares,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [W-1:0]   rnd_xor;
    logic [d*W-1:0] refreshed;
    occ_t           occupancy;
    logic           push;
    logic           pop;

    // XOR of every randomness word; applied to the last share so the
    // randomness cancels when all shares are combined.
    always_comb begin
        rnd_xor = '0;
        for (int i = 0; i < d - 1; i++) begin
            rnd_xor = rnd_xor ^ rnd[share_lsb(i, W) +: W];
        end
    end

    for (genvar i = 0; i < d - 1; i++) begin : g_share
        assign refreshed[share_lsb(i, W) +: W] =
            in_shares[share_lsb(i, W) +: W] ^ rnd[share_lsb(i, W) +: W];
    end

    assign refreshed[share_msb(d - 1, W) -: W] =
        in_shares[share_msb(d - 1, W) -: W] ^ rnd_xor;

    // Full blocks a push even when a pop frees an entry in the same cycle;
    // the freed entry becomes available the following cycle.
    assign in_ready  = (occupancy < OCC_W'(BUF_DEPTH));
    assign out_valid = (occupancy != '0);

    // rst gate keeps rnd_ready low while reset is held, since the storage
    // cannot take the item then.
    assign push      = in_valid && in_ready && rnd_valid && !rst;
    assign rnd_ready = push;
    assign pop       = out_valid && out_ready;

    shares_buf2 #(
        .DATA_W (d * W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wr_data   (refreshed),
        .rd_data   (out_shares),
        .occupancy (occupancy)
    );

`ifdef SHARES_REFRESH_STALL_CNT_EN
    logic                   stall_evt;
    logic [STALL_CNT_W-1:0] stall_q;

    assign stall_evt = in_valid && in_ready && !rnd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stall_evt && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_shares_refresh_buf.sv
// -----------------------------------------------------------------------------
// tb_shares_refresh_buf
//   Self-checking bench for shares_refresh_buf with d=2, W=8. Expected values
//   come from a queue-based model of a 2-deep FIFO of re-masked shares, a
//   table of refresh vectors, and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_shares_refresh_buf;

    localparam int D  = 2;
    localparam int W  = 8;
    localparam int DW = D * W;
    localparam int RW = (D - 1) * W;

`ifdef SHARES_REFRESH_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_shares;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] rnd;
    logic          rnd_valid;
    logic          rnd_ready;
    logic [DW-1:0] out_shares;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   stall_cnt;

    shares_refresh_buf #(
        .d (D),
        .W (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_shares  (in_shares),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rnd        (rnd),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .out_shares (out_shares),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .stall_cnt  (stall_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] popped_q[$];
    logic [15:0]   stall_exp;
    int            errors;
    int            checks;

    typedef struct {
        logic [DW-1:0] s;
        logic [RW-1:0] r;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    // Re-masking rule: share i ^= r_i for i < D-1, last share ^= XOR of all r_i.
    function automatic logic [DW-1:0] ref_refresh(input logic [DW-1:0] s,
                                                  input logic [RW-1:0] r);
        logic [W-1:0]  all_r;
        logic [DW-1:0] o;
        all_r = '0;
        o     = s;
        for (int i = 0; i < D - 1; i++) begin
            all_r           = all_r ^ r[i*W +: W];
            o[i*W +: W]     = s[i*W +: W] ^ r[i*W +: W];
        end
        o[(D-1)*W +: W] = s[(D-1)*W +: W] ^ all_r;
        return o;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [DW-1:0] s);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < D; i++) v = v ^ s[i*W +: W];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model for the inputs now applied.
    task automatic check_outputs();
        bit room;
        room = (exp_q.size() < 2);
        check("in_ready", {31'd0, in_ready}, {31'd0, room});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        check("out_shares", {16'd0, out_shares}, {16'd0, (exp_q.size() > 0) ? exp_q[0] : 16'h0000});
        check("rnd_ready", {31'd0, rnd_ready}, {31'd0, in_valid && room && rnd_valid});
        check("stall_cnt", {16'd0, stall_cnt}, {16'd0, STALL_EN ? stall_exp : 16'h0000});
    endtask

    // Advance one clock, updating the model; starts and ends at a negedge.
    task automatic tick();
        bit            push;
        bit            pop;
        logic [DW-1:0] v;
        push = in_valid && (exp_q.size() < 2) && rnd_valid;
        pop  = out_ready && (exp_q.size() > 0);
        if (in_valid && (exp_q.size() < 2) && !rnd_valid && stall_exp != 16'hFFFF)
            stall_exp = stall_exp + 16'd1;
        v = ref_refresh(in_shares, rnd);
        @(posedge clk);
        if (pop)  popped_q.push_back(exp_q.pop_front());
        if (push) exp_q.push_back(v);
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] s, input logic [RW-1:0] r,
                         input logic rv, input logic ordy);
        in_valid  = iv;
        in_shares = s;
        rnd       = r;
        rnd_valid = rv;
        out_ready = ordy;
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] s, input logic [RW-1:0] r,
                        input logic rv, input logic ordy);
        drive(iv, s, r, rv, ordy);
        #1;
        check_outputs();
        tick();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        stall_exp = 16'd0;

        vecs[0] = '{s: 16'h5AA5, r: 8'h0F, exp: 16'h55AA};
        vecs[1] = '{s: 16'h0000, r: 8'hFF, exp: 16'hFFFF};
        vecs[2] = '{s: 16'hFFFF, r: 8'hFF, exp: 16'h0000};
        vecs[3] = '{s: 16'h1234, r: 8'h00, exp: 16'h1234};
        vecs[4] = '{s: 16'h8001, r: 8'h81, exp: 16'h0180};
        vecs[5] = '{s: 16'hC33C, r: 8'h3C, exp: 16'hFF00};

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(1'b1, 16'hABCD, 8'h55, 1'b1, 1'b1);
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_rnd_ready", {31'd0, rnd_ready}, 32'd0);
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_out_shares", {16'd0, out_shares}, 32'd0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;

        // ---------------- randomness starvation: 5 cycles ----------------
        for (int i = 0; i < 5; i++) step(1'b1, 16'h5AA5, 8'h0F, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        check("starve_stall_cnt", {16'd0, stall_cnt}, STALL_EN ? 32'd5 : 32'd0);
        check("starve_no_push", {31'd0, out_valid}, 32'd0);
        #1;

        // ---------------- table of refresh vectors ----------------
        for (int k = 0; k < 6; k++) begin
            step(1'b1, vecs[k].s, vecs[k].r, 1'b1, 1'b0);
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            #1;
            check($sformatf("vec%0d_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_shares", k), {16'd0, out_shares}, {16'd0, vecs[k].exp});
            check($sformatf("vec%0d_unmask", k), {24'd0, unmask(out_shares)},
                  {24'd0, unmask(vecs[k].s)});
            step(1'b0, '0, '0, 1'b0, 1'b1);
        end
        // Entry 0 was vacated earlier; it must read zero when it is the head again.
        step(1'b0, '0, '0, 1'b0, 1'b0);

        // ---------------- back-pressure: 3 items, out_ready low ----------------
        step(1'b1, 16'h0101, 8'h00, 1'b1, 1'b0);
        step(1'b1, 16'h0202, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 16'h0303, 8'h00, 1'b1, 1'b0);
        #1;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_rnd_ready", {31'd0, rnd_ready}, 32'd0);
        check("full_head", {16'd0, out_shares}, 32'h0101);
        #1;
        step(1'b1, 16'h0303, 8'h00, 1'b1, 1'b0);
        popped_q.delete();
        step(1'b1, 16'h0303, 8'h00, 1'b1, 1'b1);
        step(1'b1, 16'h0303, 8'h00, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("order_count", popped_q.size(), 32'd3);
        if (popped_q.size() == 3) begin
            check("order_1", {16'd0, popped_q[0]}, 32'h0101);
            check("order_2", {16'd0, popped_q[1]}, 32'h0202);
            check("order_3", {16'd0, popped_q[2]}, 32'h0303);
        end

        // ---------------- occupancy 1: push and pop together ----------------
        step(1'b1, 16'h1234, 8'h11, 1'b1, 1'b0);
        step(1'b1, 16'hABCD, 8'h22, 1'b1, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        check("pp_valid", {31'd0, out_valid}, 32'd1);
        check("pp_in_ready", {31'd0, in_ready}, 32'd1);
        check("pp_shares", {16'd0, out_shares}, 32'h89EF);
        #1;
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 2) != 0);
        end

        // ---------------- async reset with buffer full ----------------
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 16'h7E7E, 8'h18, 1'b1, 1'b0);
        step(1'b1, 16'h3C3C, 8'h81, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_shares", {16'd0, out_shares}, 32'd0);
        check("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        exp_q.delete();
        stall_exp = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
